// File: rtl/uart_hex_parser_if.sv
// Byte-stream and result bundle between the UART receiver side
// and the hex line parser.
interface uart_hex_parser_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [W-1:0]  value;
    logic          value_valid;
    logic          error;
    logic [CW-1:0] digit_count;
    logic          busy;

    modport master (
        output rx_data, rx_valid,
        input  value, value_valid, error, digit_count, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output value, value_valid, error, digit_count, busy
    );
endinterface

// File: rtl/uart_hex_parser.sv
// Assembles ASCII hex digits into a right-aligned value, committing
// on CR/LF and flagging malformed lines.
module uart_hex_parser #(
    parameter int NUM_DIGITS = 4
) (
    input  logic              clock,
    input  logic              reset,
    uart_hex_parser_if.slave  bus
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DISCARD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  w_acc_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  r_value;
    logic          r_value_valid;
    logic          r_error;
    logic          w_commit;
    logic          w_fail;
    logic          w_is_digit;
    logic          w_is_term;
    logic [3:0]    w_nibble;
    logic          w_room;

    always_comb begin
        w_is_digit = 1'b0;
        w_is_term  = 1'b0;
        w_nibble   = 4'd0;
        unique case (1'b1)
            (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39): begin
                w_is_digit = 1'b1;
                w_nibble   = bus.rx_data[3:0];
            end
            (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46),
            (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66): begin
                w_is_digit = 1'b1;
                w_nibble   = bus.rx_data[3:0] + 4'd9;
            end
            (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A): begin
                w_is_term = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_room = (r_count < CW'(NUM_DIGITS));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.rx_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_digit)     w_next = S_ACCUM;
                    else if (!w_is_term) w_next = S_DISCARD;
                end
                S_ACCUM: begin
                    if (w_is_term)                w_next = S_IDLE;
                    else if (!w_is_digit || !w_room) w_next = S_DISCARD;
                end
                S_DISCARD: begin
                    if (w_is_term) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_count;
        w_commit  = 1'b0;
        w_fail    = 1'b0;
        if (bus.rx_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_acc_nxt = W'(w_nibble);
                        w_cnt_nxt = CW'(1);
                    end
                end
                S_ACCUM: begin
                    if (w_is_term) begin
                        w_commit  = 1'b1;
                        w_acc_nxt = '0;
                        w_cnt_nxt = '0;
                    end else if (w_is_digit && w_room) begin
                        w_acc_nxt = (r_acc << 4) | W'(w_nibble);
                        w_cnt_nxt = r_count + CW'(1);
                    end
                end
                S_DISCARD: begin
                    if (w_is_term) begin
                        w_fail    = 1'b1;
                        w_acc_nxt = '0;
                        w_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc         <= '0;
            r_count       <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_count       <= w_cnt_nxt;
            r_value_valid <= w_commit;
            r_error       <= w_fail;
            if (w_commit) r_value <= r_acc;
        end
    end

    assign bus.value       = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.error       = r_error;
    assign bus.digit_count = r_count;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_hex_parser.sv
// Scoreboard bench: a line model queues expected commits/errors as
// bytes are driven; a negedge monitor pops them on each DUT pulse.
module tb_uart_hex_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_hex_parser_if #(.NUM_DIGITS(4)) bus ();

    uart_hex_parser #(.NUM_DIGITS(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          err;
        logic [15:0] val;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  m_len = 0;
    bit  m_bad = 0;
    int  m_acc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int hexval(input byte b);
        string lo;
        string up;
        lo = "0123456789abcdef";
        up = "0123456789ABCDEF";
        for (int i = 0; i < 16; i++)
            if (b == lo[i] || b == up[i]) return i;
        return -1;
    endfunction

    task automatic model(input byte b);
        int n;
        ev_t e;
        n = hexval(b);
        if (n >= 0) begin
            if (!m_bad) begin
                if (m_len == 4) m_bad = 1;
                else begin
                    m_acc = (m_acc * 16 + n) & 32'hFFFF;
                    m_len++;
                end
            end
        end else if (b == 8'h0D || b == 8'h0A) begin
            if (m_bad) begin
                e.err = 1'b1;
                e.val = 16'h0;
                q.push_back(e);
            end else if (m_len > 0) begin
                e.err = 1'b0;
                e.val = m_acc[15:0];
                q.push_back(e);
            end
            m_bad = 0;
            m_len = 0;
            m_acc = 0;
        end else begin
            m_bad = 1;
        end
    endtask

    task automatic send(input byte b);
        model(b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (bus.value_valid || bus.error)) begin
            check("excl", 32'(bus.value_valid & bus.error), 0);
            if (q.size() == 0) begin
                check("unexp_pulse",
                      {30'd0, bus.value_valid, bus.error}, 0);
            end else begin
                e = q.pop_front();
                if (e.err) begin
                    check("err_pulse", 32'(bus.error), 1);
                end else begin
                    check("vv_pulse", 32'(bus.value_valid), 1);
                    check("value", 32'(bus.value), 32'(e.val));
                end
            end
        end
    end

    initial begin
        byte alpha[20];
        string a;
        a = "0123456789aAfFgG\r\n x";
        for (int i = 0; i < 20; i++) alpha[i] = a[i];

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        check("rst_value", 32'(bus.value), 0);
        check("rst_vv", 32'(bus.value_valid), 0);
        check("rst_err", 32'(bus.error), 0);
        check("rst_cnt", 32'(bus.digit_count), 0);
        check("rst_busy", 32'(bus.busy), 0);

        send("1");
        check("cnt1", 32'(bus.digit_count), 1);
        check("busy1", 32'(bus.busy), 1);
        send("F");
        check("cnt2", 32'(bus.digit_count), 2);
        send(8'h0D);
        check("cnt0", 32'(bus.digit_count), 0);
        check("vv_now", 32'(bus.value_valid), 1);
        check("v_1f", 32'(bus.value), 32'h001F);
        idle(1);
        check("vv_once", 32'(bus.value_valid), 0);

        send("a"); send("B"); send("c"); send("D");
        send(8'h0D); send(8'h0A);
        idle(2);
        check("v_abcd", 32'(bus.value), 32'hABCD);
        check("busy_abcd", 32'(bus.busy), 0);

        send("1"); send("2"); send("3"); send("4");
        check("cnt_sat", 32'(bus.digit_count), 4);
        send("5");
        check("cnt_ovf", 32'(bus.digit_count), 4);
        check("busy_ovf", 32'(bus.busy), 1);
        send(8'h0A);
        check("err_now", 32'(bus.error), 1);
        check("busy_back", 32'(bus.busy), 0);
        idle(1);
        check("err_once", 32'(bus.error), 0);
        check("v_kept", 32'(bus.value), 32'hABCD);

        send("1"); send("G"); send("2"); send(8'h0D);
        send("7"); send(8'h0D);
        idle(2);
        check("v_7", 32'(bus.value), 32'h0007);

        send(8'h0D);
        check("blank_busy0", 32'(bus.busy), 0);
        send(8'h0A);
        send(8'h0D);
        check("blank_busy", 32'(bus.busy), 0);
        idle(2);

        send("3");
        bus.rx_data = 8'h0D;
        idle(3);
        check("novalid_busy", 32'(bus.busy), 1);
        check("novalid_cnt", 32'(bus.digit_count), 1);
        send(8'h0D);
        send("8"); send(8'h0D);
        send("2"); send(8'h0D);
        idle(2);
        check("v_2", 32'(bus.value), 32'h0002);

        send("9"); send("9");
        bus.rx_data  = 8'h0D;
        bus.rx_valid = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        m_bad = 0;
        m_len = 0;
        m_acc = 0;
        check("mrst_value", 32'(bus.value), 0);
        check("mrst_vv", 32'(bus.value_valid), 0);
        check("mrst_busy", 32'(bus.busy), 0);
        check("mrst_cnt", 32'(bus.digit_count), 0);
        idle(1);
        check("mrst_vv2", 32'(bus.value_valid), 0);
        send("5"); send(8'h0D);
        idle(2);
        check("v_5", 32'(bus.value), 32'h0005);

        for (int i = 0; i < 400; i++) begin
            send(alpha[$urandom_range(19, 0)]);
            if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
        end
        send(8'h0D);
        idle(3);
        check("q_empty", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
